// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   - RNone/RPipe/RDma read-return encodings (2'd0/2'd1/2'd2)
//   - default D-MEM decode widths and the perf counter width
// Optional feature macro (used by the top): DMEM_ARB_PERF_EN.
package dmem_port_arbiter_pkg;

   localparam int unsigned DmemAddrBitsDef = 16;
   localparam int unsigned WordBitsDef     = 2;
   localparam int unsigned PerfCntBits     = 32;
   localparam int unsigned StarveCntBits   = 4;

   // Who receives the memory read data that arrives this cycle.
   typedef enum logic [1:0] {
      RNone = 2'd0,
      RPipe = 2'd1,
      RDma  = 2'd2
   } ret_state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle around the D-MEM port arbiter.
//   pipe_*  : MEM-stage request/ready/read-return channel
//   dma_*   : DMA/debug loader request/ready/read-return channel
//   mem_*   : 1-cycle-latency synchronous memory port
// Modports: slave = the arbiter, master = requesters plus memory.
interface dmem_port_arbiter_if
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned DBITS         = 32,
   parameter int unsigned ADDR_BITS     = 32,
   parameter int unsigned MEM_ADDR_BITS = DmemAddrBitsDef - WordBitsDef
);
   logic                     pipe_req;
   logic                     pipe_we;
   logic [ADDR_BITS-1:0]     pipe_addr;
   logic [DBITS-1:0]         pipe_wdata;
   logic                     pipe_ready;
   logic                     pipe_stall;
   logic                     pipe_rvalid;
   logic [DBITS-1:0]         pipe_rdata;

   logic                     dma_req;
   logic                     dma_we;
   logic [ADDR_BITS-1:0]     dma_addr;
   logic [DBITS-1:0]         dma_wdata;
   logic                     dma_ready;
   logic                     dma_rvalid;
   logic [DBITS-1:0]         dma_rdata;

   logic                     mem_en;
   logic                     mem_we;
   logic [MEM_ADDR_BITS-1:0] mem_addr;
   logic [DBITS-1:0]         mem_wdata;
   logic [DBITS-1:0]         mem_rdata;

   modport slave (
      input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
      output pipe_ready, pipe_stall, pipe_rvalid, pipe_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_ready, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output pipe_req, pipe_we, pipe_addr, pipe_wdata,
      input  pipe_ready, pipe_stall, pipe_rvalid, pipe_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_ready, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating starvation counter for the DMA requester.
//   clk, reset  : clock, asynchronous active-high reset
//   clr_i       : clear (DMA granted or not requesting); wins over inc_i
//   inc_i       : DMA requested but was denied this cycle
//   at_limit_o  : count has reached Limit
module dmem_arb_starve_ctr
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned Limit = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic at_limit_o
);
   localparam logic [StarveCntBits-1:0] LimitVal = StarveCntBits'(Limit);

   logic [StarveCntBits-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LimitVal)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LimitVal);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage has fixed priority, the DMA
// loader gets a forced grant after STARVE_LIMIT consecutive denied cycles.
// Read data from the 1-cycle-latency memory is steered back to the issuer.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : dmem_port_arbiter_if.slave (pipe_*, dma_*, mem_* channels)
//   perf_conflicts, perf_pipe_stalls : present only with DMEM_ARB_PERF_EN
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int unsigned DBITS          = 32,
   parameter int unsigned ADDR_BITS      = 32,
   parameter int unsigned DMEM_ADDR_BITS = DmemAddrBitsDef,
   parameter int unsigned WORD_BITS      = WordBitsDef,
   parameter int unsigned STARVE_LIMIT   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   dmem_port_arbiter_if.slave     bus
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [PerfCntBits-1:0] perf_conflicts,
   output logic [PerfCntBits-1:0] perf_pipe_stalls
`endif
);
   localparam int unsigned MemAddrBits = DMEM_ADDR_BITS - WORD_BITS;

   logic                   at_limit;
   logic                   force_dma;
   logic                   grant_pipe;
   logic                   grant_dma;
   logic                   mem_en;
   logic                   mem_we;
   logic [MemAddrBits-1:0] mem_addr;
   logic [DBITS-1:0]       mem_wdata;
   ret_state_e             ret_q, ret_d;

   // Upper/byte-offset address bits are not decoded by D-MEM.
   logic unused_addr;
   assign unused_addr = ^{bus.pipe_addr, bus.dma_addr};

   assign force_dma  = bus.dma_req & at_limit;
   assign grant_pipe = bus.pipe_req & ~force_dma;
   assign grant_dma  = bus.dma_req & (force_dma | ~bus.pipe_req);

   dmem_arb_starve_ctr #(
      .Limit(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (~bus.dma_req | grant_dma),
      .inc_i     (bus.dma_req & ~grant_dma),
      .at_limit_o(at_limit)
   );

   // Memory port mux and next return target.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ret_d     = RNone;
      if (grant_pipe) begin
         mem_en    = 1'b1;
         mem_we    = bus.pipe_we;
         mem_addr  = bus.pipe_addr[DMEM_ADDR_BITS-1:WORD_BITS];
         mem_wdata = bus.pipe_wdata;
         ret_d     = bus.pipe_we ? RNone : RPipe;
      end else if (grant_dma) begin
         mem_en    = 1'b1;
         mem_we    = bus.dma_we;
         mem_addr  = bus.dma_addr[DMEM_ADDR_BITS-1:WORD_BITS];
         mem_wdata = bus.dma_wdata;
         ret_d     = bus.dma_we ? RNone : RDma;
      end
   end

   // Reset drops any in-flight return immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ret_q <= RNone;
      end else begin
         ret_q <= ret_d;
      end
   end

   always_comb begin
      bus.pipe_rvalid = 1'b0;
      bus.pipe_rdata  = '0;
      bus.dma_rvalid  = 1'b0;
      bus.dma_rdata   = '0;
      unique case (ret_q)
         RPipe: begin
            bus.pipe_rvalid = 1'b1;
            bus.pipe_rdata  = bus.mem_rdata;
         end
         RDma: begin
            bus.dma_rvalid = 1'b1;
            bus.dma_rdata  = bus.mem_rdata;
         end
         default: ;
      endcase
   end

   assign bus.pipe_ready = grant_pipe;
   assign bus.dma_ready  = grant_dma;
   assign bus.pipe_stall = bus.pipe_req & ~grant_pipe;
   assign bus.mem_en     = mem_en;
   assign bus.mem_we     = mem_we;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_wdata  = mem_wdata;

`ifdef DMEM_ARB_PERF_EN
   logic [PerfCntBits-1:0] conflicts_q, stalls_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflicts_q <= '0;
         stalls_q    <= '0;
      end else begin
         if (bus.pipe_req && bus.dma_req) conflicts_q <= conflicts_q + 1'b1;
         if (bus.pipe_stall)              stalls_q    <= stalls_q + 1'b1;
      end
   end

   assign perf_conflicts   = conflicts_q;
   assign perf_pipe_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_dmem_port_arbiter;
   localparam int unsigned Limit = 4;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   dmem_port_arbiter_if #(.DBITS(32), .ADDR_BITS(32), .MEM_ADDR_BITS(14)) bus ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_conflicts, perf_pipe_stalls;
`endif

   dmem_port_arbiter #(
      .DBITS(32), .ADDR_BITS(32), .DMEM_ADDR_BITS(16), .WORD_BITS(2), .STARVE_LIMIT(Limit)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_conflicts  (perf_conflicts),
      .perf_pipe_stalls(perf_pipe_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int unsigned ret_m  = 0;  // 0 none, 1 pipe, 2 dma: who gets data this cycle
   int unsigned lost_m = 0;  // consecutive denied DMA cycles
   int unsigned win_m  = 0;  // winner of the current cycle
   logic        we_m   = 1'b0;
   logic        dreq_m = 1'b0;

   logic [2:0]  exp_grant;   // {pipe_ready, dma_ready, pipe_stall}
   logic [47:0] exp_mem;     // {mem_en, mem_we, mem_addr[13:0], mem_wdata}
   logic [65:0] exp_ret;     // {pipe_rvalid, pipe_rdata, dma_rvalid, dma_rdata}

   task automatic model_eval();
      logic [31:0] a, wd, idx;
      logic        preq, dreq;
      preq   = bus.pipe_req;
      dreq   = bus.dma_req;
      if (dreq && lost_m == Limit) win_m = 2;
      else if (preq)               win_m = 1;
      else if (dreq)               win_m = 2;
      else                         win_m = 0;
      dreq_m = dreq;
      a  = (win_m == 1) ? bus.pipe_addr  : (win_m == 2) ? bus.dma_addr  : 32'd0;
      wd = (win_m == 1) ? bus.pipe_wdata : (win_m == 2) ? bus.dma_wdata : 32'd0;
      we_m = (win_m == 1) ? bus.pipe_we : (win_m == 2) ? bus.dma_we : 1'b0;
      idx  = (a % 32'h0001_0000) / 32'd4;
      exp_grant = {win_m == 1, win_m == 2, preq && win_m != 1};
      exp_mem   = {win_m != 0, we_m, idx[13:0], wd};
      exp_ret   = {ret_m == 1, (ret_m == 1) ? bus.mem_rdata : 32'd0,
                   ret_m == 2, (ret_m == 2) ? bus.mem_rdata : 32'd0};
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ret_m  <= 0;
         lost_m <= 0;
      end else begin
         ret_m  <= (win_m != 0 && !we_m) ? win_m : 0;
         lost_m <= (!dreq_m || win_m == 2) ? 0 : ((lost_m < Limit) ? lost_m + 1 : Limit);
      end
   end

   // Drive one cycle of inputs (caller is just after a negedge) and evaluate the model.
   task automatic apply(input logic preq, input logic pwe, input logic [31:0] paddr,
                        input logic [31:0] pwd, input logic dreq, input logic dwe,
                        input logic [31:0] daddr, input logic [31:0] dwd,
                        input logic [31:0] rdata);
      bus.pipe_req   = preq;
      bus.pipe_we    = pwe;
      bus.pipe_addr  = paddr;
      bus.pipe_wdata = pwd;
      bus.dma_req    = dreq;
      bus.dma_we     = dwe;
      bus.dma_addr   = daddr;
      bus.dma_wdata  = dwd;
      bus.mem_rdata  = rdata;
      #1;
      model_eval();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
      n_checks++;
      if ({bus.pipe_rvalid, bus.dma_rvalid, bus.pipe_rdata, bus.dma_rdata} !== 66'd0)
         $display("FAIL reset_ret got %b/%b %h %h expected 0/0 0 0", bus.pipe_rvalid,
                  bus.dma_rvalid, bus.pipe_rdata, bus.dma_rdata);
      else n_pass++;
      n_checks++;
      if ({bus.mem_en, bus.mem_we, bus.pipe_ready, bus.dma_ready} !== 4'b0000)
         $display("FAIL reset_idle got en=%b we=%b pr=%b dr=%b expected all 0", bus.mem_en,
                  bus.mem_we, bus.pipe_ready, bus.dma_ready);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_pipe_read();
      @(negedge clk);
      apply(1, 0, 32'h0000_0010, 0, 0, 0, 0, 0, 32'h0);
      n_checks++;
      if ({bus.pipe_ready, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b110, 14'd4})
         $display("FAIL pipe_read_issue got ready=%b en=%b we=%b addr=%0d expected 1 1 0 4",
                  bus.pipe_ready, bus.mem_en, bus.mem_we, bus.mem_addr);
      else n_pass++;
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
      n_checks++;
      if ({bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b0})
         $display("FAIL pipe_read_ret got pv=%b pd=%h dv=%b expected 1 deadbeef 0",
                  bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid);
      else n_pass++;
   endtask

   task automatic test_dma_write();
      @(negedge clk);
      apply(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234, 32'h0);
      n_checks++;
      if ({bus.dma_ready, bus.pipe_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
          {3'b101, 14'd8, 32'h1234})
         $display("FAIL dma_write got dr=%b pr=%b we=%b addr=%0d wd=%h expected 1 0 1 8 1234",
                  bus.dma_ready, bus.pipe_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      else n_pass++;
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_5555);
      n_checks++;
      if ({bus.pipe_rvalid, bus.dma_rvalid} !== 2'b00)
         $display("FAIL dma_write_noret got pv=%b dv=%b expected 0 0", bus.pipe_rvalid,
                  bus.dma_rvalid);
      else n_pass++;
   endtask

   task automatic test_starvation();
      logic [2:0] want;
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         apply(1, 0, 32'h100 + 32'(4 * c), 0, 1, 0, 32'h200, 0, 32'hA000 + 32'(c));
         want = {c != 4, c == 4, c == 4};
         n_checks++;
         if ({bus.pipe_ready, bus.dma_ready, bus.pipe_stall} !== want)
            $display("FAIL starve_grant c=%0d got pr/dr/st=%b%b%b expected %b", c,
                     bus.pipe_ready, bus.dma_ready, bus.pipe_stall, want);
         else n_pass++;
         n_checks++;
         if (bus.dma_rvalid !== (c == 5) || (c == 5 && bus.dma_rdata !== 32'hA005))
            $display("FAIL starve_ret c=%0d got dv=%b dd=%h expected %b a005", c,
                     bus.dma_rvalid, bus.dma_rdata, c == 5);
         else n_pass++;
      end
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic test_interleaved();
      @(negedge clk);
      apply(1, 0, 32'h40, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      apply(0, 0, 0, 0, 1, 0, 32'h80, 0, 32'h1111_AAAA);
      n_checks++;
      if ({bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid, bus.dma_ready} !==
          {1'b1, 32'h1111_AAAA, 1'b0, 1'b1})
         $display("FAIL interleave_pipe got pv=%b pd=%h dv=%b dr=%b expected 1 1111aaaa 0 1",
                  bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid, bus.dma_ready);
      else n_pass++;
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h2222_BBBB);
      n_checks++;
      if ({bus.dma_rvalid, bus.dma_rdata, bus.pipe_rvalid, bus.pipe_rdata} !==
          {1'b1, 32'h2222_BBBB, 1'b0, 32'h0})
         $display("FAIL interleave_dma got dv=%b dd=%h pv=%b pd=%h expected 1 2222bbbb 0 0",
                  bus.dma_rvalid, bus.dma_rdata, bus.pipe_rvalid, bus.pipe_rdata);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      // Four conflict cycles: pipe wins all, DMA is now at the starvation limit.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         apply(1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 32'h0);
      end
      @(negedge clk);
      bus.mem_rdata = 32'hCAFE_0001;
      #1;
      n_checks++;
      if (bus.pipe_rvalid !== 1'b1)
         $display("FAIL midreset_pre got pv=%b expected 1", bus.pipe_rvalid);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid} !== 34'd0)
         $display("FAIL midreset_drop got pv=%b pd=%h dv=%b expected 0 0 0",
                  bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      apply(1, 0, 32'h300, 0, 1, 0, 32'h400, 0, 32'h0);
      n_checks++;
      if ({bus.pipe_ready, bus.dma_ready, bus.pipe_stall, bus.pipe_rvalid} !== 4'b1000)
         $display("FAIL midreset_after got pr/dr/st/pv=%b%b%b%b expected 1000",
                  bus.pipe_ready, bus.dma_ready, bus.pipe_stall, bus.pipe_rvalid);
      else n_pass++;
   endtask

   task automatic test_random();
      logic        pacc = 1'b1, dacc = 1'b1;
      logic        preq, pwe, dreq, dwe;
      logic [31:0] paddr, pwd, daddr, dwd;
      preq = 0; pwe = 0; dreq = 0; dwe = 0;
      paddr = 0; pwd = 0; daddr = 0; dwd = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         // Requesters hold an unaccepted request stable.
         if (!preq || pacc) begin
            preq  = ($urandom_range(0, 3) != 0);
            pwe   = $urandom_range(0, 1) != 0;
            paddr = $urandom;
            pwd   = $urandom;
         end
         if (!dreq || dacc) begin
            dreq  = ($urandom_range(0, 2) != 0);
            dwe   = $urandom_range(0, 1) != 0;
            daddr = $urandom;
            dwd   = $urandom;
         end
         apply(preq, pwe, paddr, pwd, dreq, dwe, daddr, dwd, $urandom);
         n_checks++;
         if ({bus.pipe_ready, bus.dma_ready, bus.pipe_stall} !== exp_grant)
            $display("FAIL rnd_grant i=%0d got %b%b%b expected %b", i, bus.pipe_ready,
                     bus.dma_ready, bus.pipe_stall, exp_grant);
         else n_pass++;
         n_checks++;
         if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== exp_mem)
            $display("FAIL rnd_mem i=%0d got %h expected %h", i,
                     {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, exp_mem);
         else n_pass++;
         n_checks++;
         if ({bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid, bus.dma_rdata} !== exp_ret)
            $display("FAIL rnd_ret i=%0d got %h expected %h", i,
                     {bus.pipe_rvalid, bus.pipe_rdata, bus.dma_rvalid, bus.dma_rdata}, exp_ret);
         else n_pass++;
         pacc = exp_grant[2];
         dacc = exp_grant[1];
      end
   endtask

`ifdef DMEM_ARB_PERF_EN
   task automatic test_perf();
      @(negedge clk);
      reset = 1'b1;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         apply(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, 32'h0);
         @(negedge clk);
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      n_checks++;
      if ({perf_conflicts, perf_pipe_stalls} !== {32'd10, 32'd2})
         $display("FAIL perf got conflicts=%0d stalls=%0d expected 10 2", perf_conflicts,
                  perf_pipe_stalls);
      else n_pass++;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      test_reset();
      test_pipe_read();
      test_dma_write();
      test_starvation();
      test_interleaved();
      test_reset_mid_read();
      test_random();
`ifdef DMEM_ARB_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
